mem_port_router: RTL

Datapath stage directly downstream of `mem_arbiter`. Takes the one-hot `gnt` vector and the per-port request buses, drives the single shared SRAM port with the granted port's access, and tracks every access through a fixed-latency tag pipeline. Each completion is returned to the originating port as a one-cycle pulse, with read data for reads. Full throughput: one access per cycle, with no stall path.

---
 rtl/mem_port_router.sv | 101 ++++++++++
 1 files changed

// File: rtl/mem_port_router.sv
// mem_port_router: drives the shared SRAM port with the granted requester's access
// and returns each completion to its originating port after a fixed latency.
//
// Parameters: PORTS requesters, ADDR_W/DATA_W SRAM widths, RD_LAT SRAM read latency (1..4).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   gnt                 one-hot grant from mem_arbiter (all-zero = idle)
//   port_addr/wdata/we  flattened per-port request buses (port i at [i*W +: W])
//   mem_en/we/addr/wdata registered SRAM access
//   mem_rdata           SRAM read data, valid RD_LAT cycles after a read mem_en
//   rsp_valid           one-hot completion pulse to the originating port
//   rsp_rdata           read data accompanying rsp_valid for reads (holds otherwise)
//   err                 sticky illegal-grant flag
// Optional feature: define MEM_ROUTER_GNT_CHK_EN to build the multi-bit grant checker;
// otherwise err is tied to 0.
module mem_port_router #(
  parameter int PORTS  = 16,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         gnt,
  input  logic [PORTS*ADDR_W-1:0]  port_addr,
  input  logic [PORTS*DATA_W-1:0]  port_wdata,
  input  logic [PORTS-1:0]         port_we,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [PORTS-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     err
);
  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int TAG_W = IDX_W + 2;
  localparam logic [PORTS-1:0] ONE = {{(PORTS-1){1'b0}}, 1'b1};
  logic [IDX_W-1:0]  w_idx;
  logic              w_any;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [TAG_W-1:0]  w_last;
  // Tag entry layout: {valid, we, idx}
  logic [TAG_W-1:0]  r_tag [RD_LAT+1];
  // Scan from the top so the lowest set bit is the last assignment and wins.
  always_comb begin
    w_idx = '0;
    for (int i = PORTS-1; i >= 0; i--)
      if (gnt[i]) w_idx = IDX_W'(i);
  end
  assign w_any   = |gnt;
  assign w_we    = port_we[w_idx];
  assign w_addr  = port_addr[w_idx*ADDR_W +: ADDR_W];
  assign w_wdata = port_wdata[w_idx*DATA_W +: DATA_W];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int i = 0; i <= RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      mem_en <= w_any;
      mem_we <= w_any & w_we;
      if (w_any) begin
        mem_addr  <= w_addr;
        mem_wdata <= w_wdata;
      end
      r_tag[0] <= {w_any, w_any & w_we, w_idx};
      for (int i = 1; i <= RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end
  // The last tag entry lines up with the cycle in which mem_rdata is valid for a read.
  assign w_last = r_tag[RD_LAT];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= w_last[TAG_W-1] ? ONE << w_last[IDX_W-1:0] : '0;
      if (w_last[TAG_W-1] && !w_last[TAG_W-2]) rsp_rdata <= mem_rdata;
    end
  end
`ifdef MEM_ROUTER_GNT_CHK_EN
  logic w_multi;
  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign w_multi = (gnt & (gnt - ONE)) != '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (w_multi) err <= 1'b1;
  end
  always @(posedge clk) begin
    if (!rst) assert (!w_multi) else $error("mem_port_router: illegal grant %h at %0t", gnt, $time);
  end
`else
  assign err = 1'b0;
`endif
endmodule
